// File: rtl/rv32i_ctrl_pipe.sv
// RV32I pipelined control: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use hazard detection and EX-stage forwarding selection.
module rv32i_ctrl_pipe #(
  parameter bit LOADUSE_EN   = 1'b1,
  parameter bit FWD_EN       = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_ext,
  input  logic        flush_e,
  output logic [2:0]  immsrc_d,
  output logic        stall_d,
  output logic        alusrc_e,
  output logic [1:0]  aluop_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic        jumpsel_e,
  output logic        illegal_e,
  output logic        valid_e,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        memwrite_m,
  output logic [1:0]  wdsel_m,
  output logic        regwrite_m,
  output logic [4:0]  rd_m,
  output logic        regwrite_w,
  output logic [1:0]  resultsrc_w,
  output logic [4:0]  rd_w
);

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // Field order matches the bundle literals used in the decoder below.
  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
    logic [2:0] immsrc;
    logic       memwrite;
    logic [1:0] wdsel;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jumpsel;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] wdsel;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jumpsel;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] wdsel;
    logic [1:0] resultsrc;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [4:0] rd;
  } wb_t;

  ctrl_t      ctrl_dec;
  ctrl_t      ctrl_id;
  logic       known_op;
  logic       illegal_id;
  logic [4:0] rd_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       loaduse;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  ex_t  ex_in;
  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;

  // funct3/funct7 do not affect the control bundle.
  logic unused_instr;
  assign unused_instr = ^{instr_d[31:25], instr_d[14:12]};

  always_comb begin
    ctrl_dec = '0;
    known_op = 1'b1;
    case (instr_d[6:0])
      OpcR:      ctrl_dec = ctrl_t'(15'b0_10_1_000_0_00_00_0_0_0);
      OpcIAlu:   ctrl_dec = ctrl_t'(15'b1_10_1_000_0_00_00_0_0_0);
      OpcLoad:   ctrl_dec = ctrl_t'(15'b1_00_1_000_0_01_01_0_0_0);
      OpcStore:  ctrl_dec = ctrl_t'(15'b1_00_0_010_1_00_00_0_0_0);
      OpcBranch: ctrl_dec = ctrl_t'(15'b0_01_0_001_0_00_00_1_0_0);
      OpcJal:    ctrl_dec = ctrl_t'(15'b0_00_1_011_0_00_10_0_1_0);
      OpcJalr:   ctrl_dec = ctrl_t'(15'b1_00_1_000_0_00_10_0_1_1);
      OpcLui:    ctrl_dec = ctrl_t'(15'b0_00_1_100_0_10_00_0_0_0);
      OpcAuipc:  ctrl_dec = ctrl_t'(15'b0_00_1_100_0_11_00_0_0_0);
      default:   known_op = 1'b0;
    endcase
  end

  // A non-instruction slot carries an all-zero bundle and rd/rs of x0.
  always_comb begin
    ctrl_id    = valid_d ? ctrl_dec : '0;
    illegal_id = TRAP_ILLEGAL && valid_d && !known_op;
    rd_id      = valid_d ? instr_d[11:7]  : 5'd0;
    rs1_id     = valid_d ? instr_d[19:15] : 5'd0;
    rs2_id     = valid_d ? instr_d[24:20] : 5'd0;
  end

  assign immsrc_d = ctrl_id.immsrc;

  always_comb begin
    ex_in           = '0;
    ex_in.valid     = valid_d;
    ex_in.alusrc    = ctrl_id.alusrc;
    ex_in.aluop     = ctrl_id.aluop;
    ex_in.regwrite  = ctrl_id.regwrite;
    ex_in.memwrite  = ctrl_id.memwrite;
    ex_in.wdsel     = ctrl_id.wdsel;
    ex_in.resultsrc = ctrl_id.resultsrc;
    ex_in.branch    = ctrl_id.branch;
    ex_in.jump      = ctrl_id.jump;
    ex_in.jumpsel   = ctrl_id.jumpsel;
    ex_in.illegal   = illegal_id;
    ex_in.rd        = rd_id;
    ex_in.rs1       = rs1_id;
    ex_in.rs2       = rs2_id;
  end

  always_comb begin
    loaduse = 1'b0;
    if (LOADUSE_EN) begin
      loaduse = ex_q.valid && (ex_q.resultsrc == 2'b01) && (ex_q.rd != 5'd0) &&
                ((ex_q.rd == instr_d[19:15]) || (ex_q.rd == instr_d[24:20]));
    end
  end

  assign stall_d = loaduse | stall_ext;

  // External stall outranks flush and load-use: a flush during a stall is dropped.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall_ext) begin
      ex_d            = (flush_e || loaduse) ? '0 : ex_in;
      mem_d.regwrite  = ex_q.regwrite;
      mem_d.memwrite  = ex_q.memwrite;
      mem_d.wdsel     = ex_q.wdsel;
      mem_d.resultsrc = ex_q.resultsrc;
      mem_d.rd        = ex_q.rd;
      wb_d.regwrite   = mem_q.regwrite;
      wb_d.resultsrc  = mem_q.resultsrc;
      wb_d.rd         = mem_q.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input mem_t m, input wb_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.regwrite && (m.rd != 5'd0) && (m.rd == rs)) begin
      sel = 2'b10;
    end else if (w.regwrite && (w.rd != 5'd0) && (w.rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN) begin
      fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);
    end
  end

  assign alusrc_e    = ex_q.alusrc;
  assign aluop_e     = ex_q.aluop;
  assign branch_e    = ex_q.branch;
  assign jump_e      = ex_q.jump;
  assign jumpsel_e   = ex_q.jumpsel;
  assign illegal_e   = ex_q.illegal;
  assign valid_e     = ex_q.valid;
  assign fwd_a_e     = fwd_a;
  assign fwd_b_e     = fwd_b;
  assign memwrite_m  = mem_q.memwrite;
  assign wdsel_m     = mem_q.wdsel;
  assign regwrite_m  = mem_q.regwrite;
  assign rd_m        = mem_q.rd;
  assign regwrite_w  = wb_q.regwrite;
  assign resultsrc_w = wb_q.resultsrc;
  assign rd_w        = wb_q.rd;

endmodule

// File: tb/tb_rv32i_ctrl_pipe.sv
// Scoreboard bench for rv32i_ctrl_pipe: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_rv32i_ctrl_pipe;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpBad   = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        valid_d, stall_ext, flush_e;
  logic [2:0]  immsrc_d;
  logic        stall_d, alusrc_e, branch_e, jump_e, jumpsel_e, illegal_e, valid_e;
  logic [1:0]  aluop_e, fwd_a_e, fwd_b_e, wdsel_m, resultsrc_w;
  logic        memwrite_m, regwrite_m, regwrite_w;
  logic [4:0]  rd_m, rd_w;

  logic        illegal_e2;
  logic [2:0]  unused_immsrc2;
  logic        unused_stall2, unused_alusrc2, unused_branch2, unused_jump2, unused_jumpsel2;
  logic        unused_valid2, unused_memwrite2, unused_regwrite_m2, unused_regwrite_w2;
  logic [1:0]  unused_aluop2, unused_fwd_a2, unused_fwd_b2, unused_wdsel2, unused_resultsrc2;
  logic [4:0]  unused_rd_m2, unused_rd_w2;

  always #5 clk = ~clk;

  rv32i_ctrl_pipe u_dut (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .valid_d(valid_d),
    .stall_ext(stall_ext), .flush_e(flush_e), .immsrc_d(immsrc_d), .stall_d(stall_d),
    .alusrc_e(alusrc_e), .aluop_e(aluop_e), .branch_e(branch_e), .jump_e(jump_e),
    .jumpsel_e(jumpsel_e), .illegal_e(illegal_e), .valid_e(valid_e), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .memwrite_m(memwrite_m), .wdsel_m(wdsel_m), .regwrite_m(regwrite_m),
    .rd_m(rd_m), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w), .rd_w(rd_w)
  );

  rv32i_ctrl_pipe #(.TRAP_ILLEGAL(1'b0)) u_dut_notrap (
    .clk(clk), .reset_n(reset_n), .instr_d(instr_d), .valid_d(valid_d),
    .stall_ext(stall_ext), .flush_e(flush_e), .immsrc_d(unused_immsrc2),
    .stall_d(unused_stall2), .alusrc_e(unused_alusrc2), .aluop_e(unused_aluop2),
    .branch_e(unused_branch2), .jump_e(unused_jump2), .jumpsel_e(unused_jumpsel2),
    .illegal_e(illegal_e2), .valid_e(unused_valid2), .fwd_a_e(unused_fwd_a2),
    .fwd_b_e(unused_fwd_b2), .memwrite_m(unused_memwrite2), .wdsel_m(unused_wdsel2),
    .regwrite_m(unused_regwrite_m2), .rd_m(unused_rd_m2), .regwrite_w(unused_regwrite_w2),
    .resultsrc_w(unused_resultsrc2), .rd_w(unused_rd_w2)
  );

  typedef enum int {
    FImmsrc, FStallD, FAlusrc, FAluop, FBranch, FJump, FJumpsel, FIllegal, FIllegal2,
    FValidE, FFwdA, FFwdB, FMemwM, FWdselM, FRegwM, FRdM, FRegwW, FResW, FRdW
  } fld_e;

  typedef struct {
    int          cyc;
    fld_e        fld;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input fld_e f);
    case (f)
      FImmsrc:   return 32'(immsrc_d);
      FStallD:   return 32'(stall_d);
      FAlusrc:   return 32'(alusrc_e);
      FAluop:    return 32'(aluop_e);
      FBranch:   return 32'(branch_e);
      FJump:     return 32'(jump_e);
      FJumpsel:  return 32'(jumpsel_e);
      FIllegal:  return 32'(illegal_e);
      FIllegal2: return 32'(illegal_e2);
      FValidE:   return 32'(valid_e);
      FFwdA:     return 32'(fwd_a_e);
      FFwdB:     return 32'(fwd_b_e);
      FMemwM:    return 32'(memwrite_m);
      FWdselM:   return 32'(wdsel_m);
      FRegwM:    return 32'(regwrite_m);
      FRdM:      return 32'(rd_m);
      FRegwW:    return 32'(regwrite_w);
      FResW:     return 32'(resultsrc_w);
      FRdW:      return 32'(rd_w);
      default:   return 'x;
    endcase
  endfunction

  function automatic void chk(input int c, input fld_e f, input logic [31:0] v,
                              input string nm);
    exp_t e;
    e.cyc = c; e.fld = f; e.exp = v; e.name = nm;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_run++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (probe(sb[i].fld) !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0h, expected %0h", sb[i].name, cyc,
                   probe(sb[i].fld), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic st,
                       output int c);
    @(posedge clk);
    #1;
    instr_d = ins; valid_d = v; flush_e = fl; stall_ext = st;
    c = cyc;
  endtask

  logic [6:0]  tbl_op  [9] = '{OpR, OpIAlu, OpLoad, OpStore, OpBr, OpJal, OpJalr, OpLui, OpAuipc};
  logic [14:0] tbl_exp [9] = '{
    15'b0_10_1_000_0_00_00_0_0_0, 15'b1_10_1_000_0_00_00_0_0_0, 15'b1_00_1_000_0_01_01_0_0_0,
    15'b1_00_0_010_1_00_00_0_0_0, 15'b0_01_0_001_0_00_00_1_0_0, 15'b0_00_1_011_0_00_10_0_1_0,
    15'b1_00_1_000_0_00_10_0_1_1, 15'b0_00_1_100_0_10_00_0_0_0, 15'b0_00_1_100_0_11_00_0_0_0};

  initial begin
    int c;
    int d;
    logic [14:0] b;
    logic [4:0] rdv;
    reset_n = 1'b0; instr_d = '0; valid_d = 1'b0; flush_e = 1'b0; stall_ext = 1'b0;

    // Reset dominates a valid instruction; stall_d still follows stall_ext.
    drive(enc(OpR, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    chk(c + 1, FValidE, 0, "rst.valid_e");
    chk(c + 1, FRegwM, 0, "rst.regwrite_m");
    chk(c + 1, FRdM, 0, "rst.rd_m");
    chk(c + 1, FRegwW, 0, "rst.regwrite_w");
    chk(c + 1, FMemwM, 0, "rst.memwrite_m");
    drive(enc(OpR, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1, c);
    reset_n = 1'b1;
    chk(c, FStallD, 1, "rst.stall_d");
    chk(c + 1, FValidE, 0, "rst.hold_valid_e");

    // ADD x3,x1,x2 latency
    drive(enc(OpR, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    chk(c, FImmsrc, 0, "add.immsrc");
    chk(c + 1, FAlusrc, 0, "add.alusrc");
    chk(c + 1, FAluop, 2, "add.aluop");
    chk(c + 1, FValidE, 1, "add.valid_e");
    chk(c + 3, FRegwW, 1, "add.regwrite_w");
    chk(c + 3, FRdW, 3, "add.rd_w");
    chk(c + 3, FResW, 0, "add.resultsrc_w");

    // Decode table across every opcode class
    for (int i = 0; i < 9; i++) begin
      b = tbl_exp[i];
      rdv = 5'(10 + i);
      drive(enc(tbl_op[i], rdv, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, c);
      chk(c, FImmsrc, 32'(b[10:8]), $sformatf("tbl%0d.immsrc", i));
      chk(c + 1, FAlusrc, 32'(b[14]), $sformatf("tbl%0d.alusrc", i));
      chk(c + 1, FAluop, 32'(b[13:12]), $sformatf("tbl%0d.aluop", i));
      chk(c + 1, FBranch, 32'(b[2]), $sformatf("tbl%0d.branch", i));
      chk(c + 1, FJump, 32'(b[1]), $sformatf("tbl%0d.jump", i));
      chk(c + 1, FJumpsel, 32'(b[0]), $sformatf("tbl%0d.jumpsel", i));
      chk(c + 1, FIllegal, 0, $sformatf("tbl%0d.illegal", i));
      chk(c + 2, FMemwM, 32'(b[7]), $sformatf("tbl%0d.memwrite_m", i));
      chk(c + 2, FWdselM, 32'(b[6:5]), $sformatf("tbl%0d.wdsel_m", i));
      chk(c + 2, FRegwM, 32'(b[11]), $sformatf("tbl%0d.regwrite_m", i));
      chk(c + 2, FRdM, 32'(rdv), $sformatf("tbl%0d.rd_m", i));
      chk(c + 3, FRegwW, 32'(b[11]), $sformatf("tbl%0d.regwrite_w", i));
      chk(c + 3, FResW, 32'(b[4:3]), $sformatf("tbl%0d.resultsrc_w", i));
      chk(c + 3, FRdW, 32'(rdv), $sformatf("tbl%0d.rd_w", i));
    end

    // Load-use: LW x5 then ADD x6,x5,x2 -> one stall, one bubble, WB forward
    drive(enc(OpLoad, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, c);
    chk(c + 1, FStallD, 1, "lu.stall_d");
    chk(c + 1, FValidE, 1, "lu.lw_in_ex");
    chk(c + 2, FStallD, 0, "lu.stall_release");
    chk(c + 2, FValidE, 0, "lu.bubble");
    chk(c + 3, FValidE, 1, "lu.add_in_ex");
    chk(c + 3, FFwdA, 1, "lu.fwd_a");
    chk(c + 3, FFwdB, 0, "lu.fwd_b");
    chk(c + 3, FRegwM, 0, "lu.mem_bubble");
    chk(c + 3, FRdW, 5, "lu.rd_w");
    chk(c + 3, FResW, 1, "lu.resultsrc_w");
    drive(enc(OpR, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0, c);

    // MEM forward, x0 never forwards, MEM beats WB, WB-only forward, squash
    drive(enc(OpR, 5'd7, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    chk(c + 2, FFwdA, 2, "fw.mem_a");
    chk(c + 2, FFwdB, 2, "fw.mem_b");
    chk(c + 4, FFwdA, 0, "fw.x0_a");
    chk(c + 4, FFwdB, 0, "fw.x0_b");
    chk(c + 7, FFwdA, 2, "fw.prio_a");
    chk(c + 7, FFwdB, 2, "fw.prio_b");
    chk(c + 10, FFwdA, 1, "fw.wb_a");
    chk(c + 10, FFwdB, 0, "fw.wb_b");
    chk(c + 10, FRegwM, 0, "sq.regwrite_m");
    chk(c + 10, FRdM, 0, "sq.rd_m");
    drive(enc(OpR, 5'd8, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd9, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd10, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd10, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd11, 5'd10, 5'd10), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd12, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd12, 5'd3, 5'd4), 1'b0, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd13, 5'd12, 5'd1), 1'b1, 1'b0, 1'b0, c);

    // JALR then flush of the following instruction
    drive(enc(OpJalr, 5'd1, 5'd5, 5'd0), 1'b1, 1'b0, 1'b0, c);
    chk(c + 1, FJump, 1, "jalr.jump");
    chk(c + 1, FJumpsel, 1, "jalr.jumpsel");
    chk(c + 2, FValidE, 0, "flush.bubble");
    chk(c + 2, FRegwM, 1, "jalr.regwrite_m");
    chk(c + 2, FRdM, 1, "jalr.rd_m");
    chk(c + 3, FRdW, 1, "jalr.rd_w");
    chk(c + 3, FResW, 2, "jalr.resultsrc_w");
    chk(c + 3, FRegwM, 0, "flush.mem_bubble");
    drive(enc(OpR, 5'd14, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0, c);

    // External stall for 3 cycles; a flush raised mid-stall is ignored
    drive(enc(OpR, 5'd18, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd17, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    drive(enc(OpR, 5'd15, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, d);
    for (int k = 1; k <= 4; k++) begin
      chk(d + k, FRdM, 17, $sformatf("stall.rd_m%0d", k));
      chk(d + k, FRdW, 18, $sformatf("stall.rd_w%0d", k));
      chk(d + k, FStallD, (k < 4) ? 1 : 0, $sformatf("stall.stall_d%0d", k));
    end
    chk(d + 5, FValidE, 1, "stall.valid_e_after");
    chk(d + 5, FRdM, 15, "stall.rd_m_after");
    chk(d + 5, FRdW, 17, "stall.rd_w_after");
    drive(enc(OpR, 5'd16, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1, c);
    drive(enc(OpR, 5'd16, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, c);
    drive(enc(OpR, 5'd16, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1, c);
    drive(enc(OpR, 5'd16, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);

    // Illegal opcode, with and without trapping; invalid slot never traps
    drive(enc(OpBad, 5'd19, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    chk(c, FImmsrc, 0, "ill.immsrc");
    chk(c + 1, FIllegal, 1, "ill.illegal_e");
    chk(c + 1, FIllegal2, 0, "ill.notrap");
    chk(c + 1, FAlusrc, 0, "ill.alusrc");
    chk(c + 1, FAluop, 0, "ill.aluop");
    chk(c + 1, FJump, 0, "ill.jump");
    chk(c + 1, FBranch, 0, "ill.branch");
    chk(c + 2, FMemwM, 0, "ill.memwrite_m");
    chk(c + 3, FRegwW, 0, "ill.regwrite_w");
    chk(c + 2, FIllegal, 0, "ill.invalid_slot");
    chk(c + 2, FValidE, 0, "ill.invalid_valid");
    drive(enc(OpBad, 5'd19, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, c);

    // flush_e together with load-use costs a single bubble
    drive(enc(OpLoad, 5'd20, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0, c);
    chk(c + 1, FStallD, 1, "fl_lu.stall_d");
    chk(c + 2, FValidE, 0, "fl_lu.bubble");
    chk(c + 2, FStallD, 0, "fl_lu.release");
    chk(c + 2, FRdM, 20, "fl_lu.rd_m");
    chk(c + 3, FValidE, 1, "fl_lu.one_bubble");
    chk(c + 3, FRegwM, 0, "fl_lu.mem_bubble");
    chk(c + 3, FRdW, 20, "fl_lu.rd_w");
    drive(enc(OpR, 5'd21, 5'd20, 5'd0), 1'b1, 1'b1, 1'b0, c);
    drive(enc(OpR, 5'd22, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);

    // Reset mid-stream: a store in flight never reaches MEM
    drive(enc(OpStore, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    chk(c, FImmsrc, 2, "rst2.sw_immsrc");
    chk(c + 1, FValidE, 1, "rst2.sw_in_ex");
    chk(c + 2, FMemwM, 0, "rst2.memwrite_m");
    chk(c + 2, FValidE, 0, "rst2.valid_e");
    chk(c + 2, FRegwW, 0, "rst2.regwrite_w");
    chk(c + 2, FRdW, 0, "rst2.rd_w");
    chk(c + 3, FMemwM, 0, "rst2.memwrite_m_next");
    drive(enc(OpR, 5'd23, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, c);
    reset_n = 1'b0;
    drive(32'd0, 1'b0, 1'b0, 1'b0, c);
    reset_n = 1'b1;

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
